// File: rtl/ising_lattice_engine.sv
// Ising lattice engine: toroidal ROWS x COLS spin lattice with a checkerboard Metropolis
// update. Each run updates the white sites, then the grey sites, for num_sweeps sweeps.
// Acceptance uses a per-site word rotated out of a 32-bit Galois LFSR.
module ising_lattice_engine #(
  parameter int unsigned ROWS    = 8,
  parameter int unsigned COLS    = 8,
  parameter int unsigned SWEEP_W = 16,
  parameter int unsigned RA_W    = $clog2(ROWS),
  parameter int unsigned MAG_W   = $clog2(ROWS * COLS + 1)
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic [SWEEP_W-1:0] num_sweeps,
  input  logic [16:0]        thr4,
  input  logic [16:0]        thr8,
  input  logic               seed_load,
  input  logic [31:0]        seed,
  input  logic               wr_en,
  input  logic [RA_W-1:0]    wr_row,
  input  logic [COLS-1:0]    wr_data,
  input  logic [RA_W-1:0]    rd_row,
  output logic [COLS-1:0]    rd_data,
  output logic               busy,
  output logic               done,
  output logic [MAG_W-1:0]   magnetisation
);

  localparam logic [31:0] LfsrTaps = 32'h8020_0003;

  typedef enum logic [1:0] {StIdle, StWhite, StGrey, StDone} state_e;

  state_e                       state_q, state_d;
  logic [ROWS-1:0][COLS-1:0]    lat_q, lat_d;
  logic [ROWS-1:0][COLS-1:0]    flip;
  logic [31:0]                  rng_q, rng_d;
  logic [SWEEP_W-1:0]           cnt_q, cnt_d;
  logic [SWEEP_W-1:0]           n_q, n_d;
  logic [MAG_W-1:0]             mag_q, mag_d;

  // Per-site flip decision from the current lattice and RNG word. A site's "agree" count is the
  // number of neighbours with the same spin: 4 means dE=+8, 3 means dE=+4, fewer means dE<=0.
  always_comb begin
    logic [2:0]  ones;
    logic [2:0]  agree;
    logic [63:0] dbl;
    logic [16:0] u17;
    flip  = '0;
    ones  = '0;
    agree = '0;
    dbl   = '0;
    u17   = '0;
    for (int r = 0; r < ROWS; r++) begin
      for (int c = 0; c < COLS; c++) begin
        ones = {2'b00, lat_q[(r + 1) % ROWS][c]}
             + {2'b00, lat_q[(r + ROWS - 1) % ROWS][c]}
             + {2'b00, lat_q[r][(c + 1) % COLS]}
             + {2'b00, lat_q[r][(c + COLS - 1) % COLS]};
        agree = lat_q[r][c] ? ones : (3'd4 - ones);
        // Upper half of {R,R} << k is R rotated left by k.
        dbl = {rng_q, rng_q} << ((r * COLS + c) % 32);
        u17 = {1'b0, dbl[47:32]};
        if (agree == 3'd4) begin
          flip[r][c] = (u17 < thr8);
        end else if (agree == 3'd3) begin
          flip[r][c] = (u17 < thr4);
        end else begin
          flip[r][c] = 1'b1;
        end
      end
    end
  end

  // Lattice next state: row writes in idle, one colour class per update cycle.
  always_comb begin
    lat_d = lat_q;
    unique case (state_q)
      StIdle: begin
        if (wr_en && (32'(wr_row) < ROWS)) begin
          lat_d[wr_row] = wr_data;
        end
      end
      StWhite, StGrey: begin
        for (int r = 0; r < ROWS; r++) begin
          for (int c = 0; c < COLS; c++) begin
            if (((((r + c) % 2) == 0) == (state_q == StWhite)) && flip[r][c]) begin
              lat_d[r][c] = ~lat_q[r][c];
            end
          end
        end
      end
      default: ;
    endcase
  end

  // Run control FSM and RNG sequencing.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    n_d     = n_q;
    rng_d   = rng_q;
    unique case (state_q)
      StIdle: begin
        if (seed_load) begin
          rng_d = (seed == 32'h0) ? 32'h1 : seed;
        end
        if (start) begin
          n_d     = num_sweeps;
          cnt_d   = '0;
          state_d = (num_sweeps == '0) ? StDone : StWhite;
        end
      end
      StWhite: begin
        rng_d   = (rng_q >> 1) ^ (rng_q[0] ? LfsrTaps : 32'h0);
        state_d = StGrey;
      end
      StGrey: begin
        rng_d = (rng_q >> 1) ^ (rng_q[0] ? LfsrTaps : 32'h0);
        // Compare against N-1 so the counter never has to hold N itself.
        if (cnt_q == (n_q - SWEEP_W'(1))) begin
          state_d = StDone;
        end else begin
          cnt_d   = cnt_q + SWEEP_W'(1);
          state_d = StWhite;
        end
      end
      StDone: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  // Magnetisation captured from the lattice value entering DONE.
  always_comb begin
    mag_d = mag_q;
    if (state_d == StDone) begin
      mag_d = '0;
      for (int r = 0; r < ROWS; r++) begin
        for (int c = 0; c < COLS; c++) begin
          mag_d = mag_d + MAG_W'(lat_d[r][c]);
        end
      end
    end
  end

  // Live row readback.
  always_comb begin
    rd_data = '0;
    if (32'(rd_row) < ROWS) begin
      rd_data = lat_q[rd_row];
    end
  end

  // State registers with asynchronous active-high reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= StIdle;
      lat_q   <= '0;
      rng_q   <= 32'h1;
      cnt_q   <= '0;
      n_q     <= '0;
      mag_q   <= '0;
    end else begin
      state_q <= state_d;
      lat_q   <= lat_d;
      rng_q   <= rng_d;
      cnt_q   <= cnt_d;
      n_q     <= n_d;
      mag_q   <= mag_d;
    end
  end

  assign busy          = (state_q == StWhite) || (state_q == StGrey);
  assign done          = (state_q == StDone);
  assign magnetisation = mag_q;

endmodule

// File: tb/tb_ising_lattice_engine.sv
// Bench for ising_lattice_engine: a spin-level (+1/-1) reference model checked every cycle,
// plus directed runs with literal expectations.
module tb_ising_lattice_engine;

  localparam int ROWS    = 8;
  localparam int COLS    = 8;
  localparam int SWEEP_W = 16;
  localparam int RA_W    = 3;
  localparam int MAG_W   = 7;

  logic               clk = 1'b0;
  logic               reset;
  logic               start;
  logic [SWEEP_W-1:0] num_sweeps;
  logic [16:0]        thr4;
  logic [16:0]        thr8;
  logic               seed_load;
  logic [31:0]        seed;
  logic               wr_en;
  logic [RA_W-1:0]    wr_row;
  logic [COLS-1:0]    wr_data;
  logic [RA_W-1:0]    rd_row;
  logic [COLS-1:0]    rd_data;
  logic               busy;
  logic               done;
  logic [MAG_W-1:0]   magnetisation;

  always #10 clk = ~clk;

  ising_lattice_engine #(
    .ROWS(ROWS), .COLS(COLS), .SWEEP_W(SWEEP_W), .RA_W(RA_W), .MAG_W(MAG_W)
  ) dut (
    .clk(clk), .reset(reset), .start(start), .num_sweeps(num_sweeps), .thr4(thr4),
    .thr8(thr8), .seed_load(seed_load), .seed(seed), .wr_en(wr_en), .wr_row(wr_row),
    .wr_data(wr_data), .rd_row(rd_row), .rd_data(rd_data), .busy(busy), .done(done),
    .magnetisation(magnetisation)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // ---------------- reference model (spins as +1/-1 integers) ----------------
  typedef enum {MIdle, MRun, MDone} mmode_e;
  mmode_e      m_mode = MIdle;
  int          m_spin [ROWS][COLS];
  logic [31:0] m_r    = 32'h1;
  int          m_left = 0;
  bit          m_white = 1'b1;
  int          m_mag  = 0;

  function automatic logic [31:0] rotl(input logic [31:0] x, input int k);
    if (k == 0) return x;
    return (x << k) | (x >> (32 - k));
  endfunction

  function automatic logic [31:0] lfsr_next(input logic [31:0] x);
    return (x >> 1) ^ (x[0] ? 32'h8020_0003 : 32'h0);
  endfunction

  function automatic int m_count();
    int n = 0;
    for (int r = 0; r < ROWS; r++)
      for (int c = 0; c < COLS; c++)
        if (m_spin[r][c] == 1) n++;
    return n;
  endfunction

  function automatic logic [COLS-1:0] m_row(input int r);
    logic [COLS-1:0] v = '0;
    for (int c = 0; c < COLS; c++) v[c] = (m_spin[r][c] == 1);
    return v;
  endfunction

  task automatic m_phase(input bit white);
    for (int r = 0; r < ROWS; r++) begin
      for (int c = 0; c < COLS; c++) begin
        if (((((r + c) % 2) == 0) ? 1'b1 : 1'b0) == white) begin
          int          s;
          int          sum;
          int          de;
          int          u;
          logic [31:0] rot;
          bit          f;
          s   = m_spin[r][c];
          sum = m_spin[(r + 1) % ROWS][c] + m_spin[(r + ROWS - 1) % ROWS][c]
              + m_spin[r][(c + 1) % COLS] + m_spin[r][(c + COLS - 1) % COLS];
          de  = 2 * s * sum;
          rot = rotl(m_r, (r * COLS + c) % 32);
          u   = int'(rot[15:0]);
          if (de <= 0) f = 1'b1;
          else if (de == 4) f = (u < int'(thr4));
          else f = (u < int'(thr8));
          if (f) m_spin[r][c] = -s;
        end
      end
    end
  endtask

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      m_mode = MIdle;
      m_r    = 32'h1;
      m_mag  = 0;
      for (int r = 0; r < ROWS; r++)
        for (int c = 0; c < COLS; c++) m_spin[r][c] = -1;
    end else begin
      case (m_mode)
        MIdle: begin
          if (wr_en)
            for (int c = 0; c < COLS; c++) m_spin[wr_row][c] = wr_data[c] ? 1 : -1;
          if (seed_load) m_r = (seed == 32'h0) ? 32'h1 : seed;
          if (start) begin
            if (num_sweeps == 0) begin
              m_mode = MDone;
              m_mag  = m_count();
            end else begin
              m_left  = 2 * int'(num_sweeps);
              m_white = 1'b1;
              m_mode  = MRun;
            end
          end
        end
        MRun: begin
          m_phase(m_white);
          m_r     = lfsr_next(m_r);
          m_white = !m_white;
          m_left--;
          if (m_left == 0) begin
            m_mode = MDone;
            m_mag  = m_count();
          end
        end
        default: m_mode = MIdle;
      endcase
    end
  end

  // Every-cycle comparison against the model.
  always @(negedge clk) begin
    chk("busy", busy, (m_mode == MRun));
    chk("done", done, (m_mode == MDone));
    chk("magnetisation", magnetisation, m_mag);
    chk("rd_data", rd_data, m_row(rd_row));
  end

  // ---------------- stimulus ----------------
  task automatic tick();
    @(posedge clk);
    #1;
    rd_row = rd_row + 1'b1;
  endtask

  task automatic write_row(input int r, input logic [COLS-1:0] v);
    wr_en   = 1'b1;
    wr_row  = RA_W'(r);
    wr_data = v;
    tick();
    wr_en   = 1'b0;
  endtask

  task automatic check_all_lit(input string name, input logic [COLS-1:0] v);
    for (int r = 0; r < ROWS; r++) begin
      rd_row = RA_W'(r);
      #1;
      chk(name, rd_data, v);
    end
  endtask

  // Starts a run and waits (bounded) for done; poke>0 asserts start/wr_en after that edge.
  task automatic run(input int n, input int poke, output int cyc);
    num_sweeps = SWEEP_W'(n);
    start      = 1'b1;
    tick();
    start     = 1'b0;
    wr_en     = 1'b0;
    seed_load = 1'b0;
    cyc       = 1;
    while (!done && cyc < 2 * n + 20) begin
      if (cyc == poke) begin
        start   = 1'b1;
        wr_en   = 1'b1;
        wr_row  = '0;
        wr_data = 8'h5A;
      end else begin
        start = 1'b0;
        wr_en = 1'b0;
      end
      tick();
      cyc++;
    end
    start = 1'b0;
    wr_en = 1'b0;
    chk("run_done_seen", done, 1'b1);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, required finish within time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    int cyc;
    reset      = 1'b1;
    start      = 1'b0;
    num_sweeps = '0;
    thr4       = '0;
    thr8       = '0;
    seed_load  = 1'b0;
    seed       = '0;
    wr_en      = 1'b0;
    wr_row     = '0;
    wr_data    = '0;
    rd_row     = '0;
    tick();
    tick();
    reset = 1'b0;
    tick();

    // Reset state.
    chk("reset_busy", busy, 1'b0);
    chk("reset_done", done, 1'b0);
    chk("reset_mag", magnetisation, 0);
    check_all_lit("reset_lattice", 8'h00);

    // All ones, N=0: done next cycle, lattice unchanged.
    for (int r = 0; r < ROWS; r++) write_row(r, 8'hFF);
    run(0, 0, cyc);
    chk("n0_latency", cyc, 1);
    chk("n0_mag", magnetisation, 64);
    tick();
    check_all_lit("n0_lattice", 8'hFF);

    // All ones, always accept: everything flips to 0 in one sweep.
    thr4 = 17'h10000;
    thr8 = 17'h10000;
    run(1, 0, cyc);
    chk("acc_latency", cyc, 3);
    chk("acc_mag", magnetisation, 0);
    tick();
    check_all_lit("acc_lattice", 8'h00);

    // Checkerboard, never accept: whites flip down, greys hold.
    thr4 = '0;
    thr8 = '0;
    for (int r = 0; r < ROWS; r++) write_row(r, (r % 2 == 0) ? 8'h55 : 8'hAA);
    run(1, 0, cyc);
    chk("cb_latency", cyc, 3);
    chk("cb_mag", magnetisation, 0);
    tick();
    check_all_lit("cb_lattice", 8'h00);

    // All ones, never accept, long run.
    for (int r = 0; r < ROWS; r++) write_row(r, 8'hFF);
    run(1000, 0, cyc);
    chk("long_latency", cyc, 2001);
    chk("long_mag", magnetisation, 64);
    tick();
    check_all_lit("long_lattice", 8'hFF);

    // Random lattice with seed; last write, seed load and start share one cycle.
    thr4 = 17'h4000;
    thr8 = 17'h1000;
    for (int r = 0; r < ROWS - 1; r++) write_row(r, COLS'($urandom));
    wr_en     = 1'b1;
    wr_row    = RA_W'(ROWS - 1);
    wr_data   = COLS'($urandom);
    seed_load = 1'b1;
    seed      = 32'hDEAD_BEEF;
    run(5, 3, cyc);
    chk("rand_latency", cyc, 11);
    for (int r = 0; r < ROWS; r++) begin
      rd_row = RA_W'(r);
      #1;
      chk("rand_final_row", rd_data, m_row(r));
    end
    tick();

    // Reset during the third grey cycle.
    for (int r = 0; r < ROWS; r++) write_row(r, COLS'($urandom));
    num_sweeps = 16'd5;
    start      = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 0; i < 5; i++) tick();
    chk("pre_reset_busy", busy, 1'b1);
    #1;
    reset = 1'b1;
    #1;
    chk("midrun_reset_busy", busy, 1'b0);
    chk("midrun_reset_done", done, 1'b0);
    check_all_lit("midrun_reset_lattice", 8'h00);
    tick();
    reset = 1'b0;
    for (int i = 0; i < 6; i++) begin
      tick();
      chk("no_done_after_reset", done, 1'b0);
    end

    // Zero seed loads as 1; the model checks the resulting run.
    seed_load = 1'b1;
    seed      = 32'h0;
    tick();
    seed_load = 1'b0;
    for (int r = 0; r < ROWS; r++) write_row(r, COLS'($urandom));
    run(2, 0, cyc);
    chk("seed0_latency", cyc, 5);
    tick();
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
